// File: rtl/synth_reg_tx.sv
// Host-side nibble-serial register-write transmitter.
// Buffers (addr, data) requests in a small FIFO and sends each as a frame of
// three nibbles (addr, data[7:4], data[3:0]), each held HOLD cycles, followed
// by one idle gap cycle.
module synth_reg_tx #(
    parameter int DEPTH = 4,
    parameter int HOLD  = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [3:0]                 in_addr,
    input  logic [7:0]                 in_data,
    output logic [3:0]                 tx_nibble,
    output logic                       tx_strobe,
    output logic                       tx_first,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH) + 1;
    localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DHI,
        S_DLO,
        S_GAP
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [11:0]     frame_q, frame_d;
    logic [11:0]     mem_q [DEPTH];
    logic [11:0]     mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;

    logic            push;
    logic            pop;

    assign in_ready = (level_q != LW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign level    = level_q;
    assign busy     = (state_q != S_IDLE) || (level_q != '0);

    // FIFO storage, pointers and occupancy
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            mem_d[wr_ptr_q] = {in_addr, in_data};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Frame sequencer: loads the FIFO head in IDLE/GAP, steps nibbles every HOLD cycles
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        frame_d = frame_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE, S_GAP: begin
                if (level_q != '0) begin
                    pop     = 1'b1;
                    frame_d = mem_q[rd_ptr_q];
                    cnt_d   = '0;
                    state_d = S_ADDR;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ADDR, S_DHI, S_DLO: begin
                if (cnt_q == CW'(HOLD - 1)) begin
                    cnt_d = '0;
                    case (state_q)
                        S_ADDR:  state_d = S_DHI;
                        S_DHI:   state_d = S_DLO;
                        default: state_d = S_GAP;
                    endcase
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Bus decode from registered state and frame only
    always_comb begin
        tx_nibble = '0;
        tx_strobe = 1'b0;
        tx_first  = 1'b0;
        case (state_q)
            S_ADDR: begin
                tx_nibble = frame_q[11:8];
                tx_strobe = (cnt_q == '0);
                tx_first  = 1'b1;
            end
            S_DHI: begin
                tx_nibble = frame_q[7:4];
                tx_strobe = (cnt_q == '0);
            end
            S_DLO: begin
                tx_nibble = frame_q[3:0];
                tx_strobe = (cnt_q == '0);
            end
            default: ;
        endcase
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            frame_q  <= '0;
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            frame_q  <= frame_d;
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: tb/tb_synth_reg_tx.sv
// Bench for synth_reg_tx: a HOLD=2 and a HOLD=1 instance checked every cycle
// against a behavioural model that tracks a request list and frame position.
module tb_synth_reg_tx;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       a_valid = 1'b0, b_valid = 1'b0;
    logic [3:0] a_addr = '0, b_addr = '0;
    logic [7:0] a_data = '0, b_data = '0;
    logic       a_ready, b_ready;
    logic [3:0] a_nib, b_nib;
    logic       a_stb, b_stb, a_first, b_first, a_busy, b_busy;
    logic [2:0] a_level, b_level;

    int tests = 0;
    int fails = 0;

    synth_reg_tx #(.DEPTH(DEPTH), .HOLD(2)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_valid), .in_ready(a_ready), .in_addr(a_addr), .in_data(a_data),
        .tx_nibble(a_nib), .tx_strobe(a_stb), .tx_first(a_first),
        .busy(a_busy), .level(a_level)
    );

    synth_reg_tx #(.DEPTH(DEPTH), .HOLD(1)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_valid), .in_ready(b_ready), .in_addr(b_addr), .in_data(b_data),
        .tx_nibble(b_nib), .tx_strobe(b_stb), .tx_first(b_first),
        .busy(b_busy), .level(b_level)
    );

    always #5 clk = ~clk;

    // Model: pending requests as an ordered list, current frame as a cycle position
    int          hold_of [2] = '{2, 1};
    logic [11:0] m_list  [2][16];
    int          m_cnt   [2];
    bit          m_act   [2];
    int          m_pos   [2];
    logic [11:0] m_frame [2];
    int          peak;

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i]   = 0;
            m_act[i]   = 1'b0;
            m_pos[i]   = 0;
            m_frame[i] = '0;
        end
    endtask

    task automatic model_edge(input int i, input logic v, input logic [3:0] ad, input logic [7:0] d);
        int  pre;
        bit  take;
        pre  = m_cnt[i];
        take = v && (pre != DEPTH);
        if (m_act[i]) begin
            m_pos[i]++;
            if (m_pos[i] > 3 * hold_of[i]) m_act[i] = 1'b0;
        end
        if (take) begin
            m_list[i][m_cnt[i]] = {ad, d};
            m_cnt[i]++;
        end
        if (!m_act[i] && pre != 0) begin
            m_frame[i] = m_list[i][0];
            for (int k = 0; k < 15; k++) m_list[i][k] = m_list[i][k+1];
            m_cnt[i]--;
            m_act[i] = 1'b1;
            m_pos[i] = 0;
        end
    endtask

    task automatic check(input int i, input string tag);
        logic [10:0] obs, exp;
        logic [3:0]  en;
        logic        es, ef;
        int          h, seg;
        h  = hold_of[i];
        en = '0; es = 1'b0; ef = 1'b0;
        if (m_act[i]) begin
            seg = m_pos[i] / h;
            if (seg < 3) begin
                en = (seg == 0) ? m_frame[i][11:8] : (seg == 1) ? m_frame[i][7:4] : m_frame[i][3:0];
                es = ((m_pos[i] % h) == 0);
                ef = (seg == 0);
            end
        end
        exp = {en, es, ef, (m_act[i] || m_cnt[i] != 0), (m_cnt[i] != DEPTH), 3'(m_cnt[i])};
        if (i == 0) obs = {a_nib, a_stb, a_first, a_busy, a_ready, a_level};
        else        obs = {b_nib, b_stb, b_first, b_busy, b_ready, b_level};
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s inst%0d {nib,stb,first,busy,ready,level}: got %h expected %h", tag, i, obs, exp);
        end
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge(0, a_valid, a_addr, a_data);
        model_edge(1, b_valid, b_addr, b_data);
        #1;
        check(0, tag);
        check(1, tag);
        if (int'(a_level) > peak) peak = int'(a_level);
    endtask

    task automatic drive_a(input logic v, input logic [3:0] ad, input logic [7:0] d);
        a_valid = v; a_addr = ad; a_data = d;
    endtask

    task automatic drive_b(input logic v, input logic [3:0] ad, input logic [7:0] d);
        b_valid = v; b_addr = ad; b_data = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        model_reset();
        peak = 0;

        // Reset state
        #1;
        check(0, "reset");
        check(1, "reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single write on HOLD=2
        drive_a(1'b1, 4'h5, 8'hA3);
        cycle("single_push");
        drive_a(1'b0, 4'h0, 8'h00);
        repeat (12) cycle("single");

        // Back-to-back three writes, occupancy peaks at 2
        peak = 0;
        drive_a(1'b1, 4'h1, 8'h12); cycle("b2b");
        drive_a(1'b1, 4'h2, 8'h34); cycle("b2b");
        drive_a(1'b1, 4'h3, 8'h56); cycle("b2b");
        drive_a(1'b0, 4'h0, 8'h00);
        repeat (24) cycle("b2b");
        tests++;
        assert (peak === 2) else begin
            fails++;
            $error("FAIL b2b_peak: got %0d expected %0d", peak, 2);
        end

        // Backpressure, then keep pushing through pops while full
        for (int k = 0; k < 30; k++) begin
            drive_a(1'b1, 4'(k), 8'(k + 8'h40));
            cycle("bp");
        end
        drive_a(1'b0, 4'h0, 8'h00);
        repeat (45) cycle("bp_drain");

        // HOLD=1: two identical frames, period 4
        drive_b(1'b1, 4'hF, 8'hFF); cycle("h1");
        cycle("h1");
        drive_b(1'b0, 4'h0, 8'h00);
        repeat (10) cycle("h1");

        // Reset during the DHI nibble with two requests still queued
        drive_a(1'b1, 4'h7, 8'h9C); cycle("rst_fill");
        drive_a(1'b1, 4'h8, 8'hA1); cycle("rst_fill");
        drive_a(1'b1, 4'h9, 8'hB2); cycle("rst_fill");
        drive_a(1'b0, 4'h0, 8'h00);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (a_stb && !a_first) found = 1'b1;
            else cycle("rst_wait");
        end
        tests++;
        assert (found) else begin
            fails++;
            $error("FAIL rst_wait_dhi: got no DHI strobe, expected one within 20 cycles");
        end
        rst_n = 1'b0;
        model_reset();
        #1;
        check(0, "rst_async");
        check(1, "rst_async");
        #2 rst_n = 1'b1;
        repeat (5) cycle("rst_quiet");
        drive_a(1'b1, 4'hC, 8'h3E); cycle("rst_new");
        drive_a(1'b0, 4'h0, 8'h00);
        repeat (12) cycle("rst_new");

        // Randomized traffic on both instances
        for (int k = 0; k < 300; k++) begin
            drive_a(1'($urandom_range(0, 1)), 4'($urandom), 8'($urandom));
            drive_b(1'($urandom_range(0, 3) == 0), 4'($urandom), 8'($urandom));
            cycle("rand");
        end
        drive_a(1'b0, 4'h0, 8'h00);
        drive_b(1'b0, 4'h0, 8'h00);
        repeat (40) cycle("rand_drain");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
